// File: rtl/req_encoder_pkg.sv
// rtl/req_encoder_pkg.sv - shared types and limits for the request encoder
//
// Purpose:
//   Holds the handshake FSM state type and the supported upper bound on the
//   number of request lines. Imported by req_encoder and prio_find_first.
//
// Contents:
//   state_t  : S_IDLE (nothing presented), S_VALID (an index is presented)
//   N_MAX    : largest supported request-line count
package req_encoder_pkg;

  localparam int N_MAX = 32;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_VALID = 1'b1
  } state_t;

endpackage : req_encoder_pkg

// File: rtl/prio_find_first.sv
// rtl/prio_find_first.sv - rotating find-first-set over an N-bit vector
//
// Purpose:
//   Combinational search for the first set bit of vec, starting at bit
//   position 'start' and wrapping from N-1 back to 0. With start tied to 0
//   this is a plain lowest-index priority encoder.
//
// Ports:
//   vec    in   N  candidate bits
//   start  in   W  first position examined (values >= N are treated as 0)
//   idx    out  W  index of the first set bit found (0 when none)
//   any    out  1  at least one bit of vec is set
module prio_find_first #(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] vec,
  input  logic [W-1:0] start,
  output logic [W-1:0] idx,
  output logic         any
);

  import req_encoder_pkg::*;

  // Two copies back to back so a wrapped search is a straight walk upward.
  logic [2*N-1:0] vec2;
  int             start_c;
  int             pos;

  assign vec2 = {vec, vec};

  always_comb begin
    idx     = '0;
    any     = 1'b0;
    pos     = 0;
    start_c = (int'(start) < N) ? int'(start) : 0;
    for (int i = 0; i < N; i++) begin
      pos = start_c + i;
      if (!any && vec2[pos]) begin
        any = 1'b1;
        idx = W'((pos >= N) ? (pos - N) : pos);
      end
    end
  end

endmodule : prio_find_first

// File: rtl/req_encoder.sv
// rtl/req_encoder.sv - sticky request capture with one-grant-per-cycle binary output
//
// Purpose:
//   Captures N request lines into sticky pending bits and presents the
//   binary index of one pending request at a time on a valid/ready output.
//   The presented bit is cleared when the consumer accepts it. A request
//   arriving on the same edge as its own clear wins, so it stays pending.
//
// Build option:
//   REQ_ENCODER_ROUND_ROBIN_EN defined   -> rotating priority; the search
//     starts one past the last accepted index, tracked in a W-bit pointer.
//   REQ_ENCODER_ROUND_ROBIN_EN undefined -> fixed lowest-index priority, no
//     pointer register.
//   The port list is the same in both builds.
//
// Ports:
//   clk        in   1  rising-edge clock
//   rst_n      in   1  asynchronous active-low reset
//   ena        in   1  capture enable; 0 ignores req this cycle
//   req        in   N  request pulses/levels, sampled every edge
//   out_ready  in   1  consumer accepts out this cycle
//   out_valid  out  1  out holds a valid index
//   out        out  W  binary index of the granted request
//   pending    out  N  sticky pending bits
module req_encoder #(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ena,
  input  logic [N-1:0] req,
  input  logic         out_ready,
  output logic         out_valid,
  output logic [W-1:0] out,
  output logic [N-1:0] pending
);

  import req_encoder_pkg::*;

  state_t         state_q, state_d;
  logic [W-1:0]   out_q, out_d;
  logic           out_valid_q, out_valid_d;
  logic [N-1:0]   pending_q, pending_d;

  logic [N-1:0]   eff_req;
  logic [N-1:0]   clr;
  logic           handshake;
  logic [W-1:0]   search_start;
  logic [W-1:0]   find_idx;
  logic           find_any;

  // Capture and clear. Candidates for the next grant are exactly the next
  // pending set, so a bit re-requested on its own acceptance cycle can be
  // presented again without a bubble on out_valid.
  always_comb begin
    eff_req   = ena ? req : '0;
    handshake = out_valid_q & out_ready;
    clr       = handshake ? ({{(N-1){1'b0}}, 1'b1} << out_q) : '0;
    pending_d = ((pending_q | eff_req) & ~clr) | eff_req;
  end

`ifdef REQ_ENCODER_ROUND_ROBIN_EN
  logic [W-1:0] ptr_q, ptr_d;

  function automatic logic [W-1:0] wrap_inc(input logic [W-1:0] v);
    wrap_inc = (v == W'(N - 1)) ? '0 : v + 1'b1;
  endfunction

  // On an acceptance the new grant must already search from one past the
  // index being retired, so the start bypasses the pointer register.
  always_comb begin
    ptr_d        = handshake ? wrap_inc(out_q) : ptr_q;
    search_start = ptr_d;
  end
`else
  assign search_start = '0;
`endif

  prio_find_first #(
    .N (N),
    .W (W)
  ) u_find (
    .vec   (pending_d),
    .start (search_start),
    .idx   (find_idx),
    .any   (find_any)
  );

  // Handshake FSM. While presenting without out_ready nothing moves, even
  // if a higher-priority request shows up. out keeps its last value when
  // out_valid drops.
  always_comb begin
    state_d     = state_q;
    out_d       = out_q;
    out_valid_d = out_valid_q;
    case (state_q)
      S_IDLE: begin
        if (find_any) begin
          out_d       = find_idx;
          out_valid_d = 1'b1;
          state_d     = S_VALID;
        end
      end
      S_VALID: begin
        if (out_ready) begin
          if (find_any) begin
            out_d       = find_idx;
            out_valid_d = 1'b1;
          end else begin
            out_valid_d = 1'b0;
            state_d     = S_IDLE;
          end
        end
      end
      default: begin
        out_valid_d = 1'b0;
        state_d     = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      pending_q   <= '0;
`ifdef REQ_ENCODER_ROUND_ROBIN_EN
      ptr_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      pending_q   <= pending_d;
`ifdef REQ_ENCODER_ROUND_ROBIN_EN
      ptr_q       <= ptr_d;
`endif
    end
  end

  assign out_valid = out_valid_q;
  assign out       = out_q;
  assign pending   = pending_q;

endmodule : req_encoder

// File: tb/tb_req_encoder.sv
// tb/tb_req_encoder.sv - self-checking bench for req_encoder (N=4) against a behavioural model
module tb_req_encoder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [3:0] req;
  logic       out_ready;
  logic       out_valid;
  logic [1:0] out;
  logic [3:0] pending;

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model: a set of pending request numbers, the number being
  // offered (if any) and the last number the consumer took.
  bit m_pend [4];
  bit m_valid;
  int m_out;
  int m_last;

  req_encoder #(.N(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .req       (req),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out       (out),
    .pending   (pending)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_pend[i] = 1'b0;
    m_valid = 1'b0;
    m_out   = 0;
    m_last  = 3;
  endtask

  function automatic logic [3:0] model_pend_vec();
    logic [3:0] v;
    for (int i = 0; i < 4; i++) v[i] = m_pend[i];
    return v;
  endfunction

  // One clock edge of the consumer/producer story.
  task automatic model_step(input logic e, input logic [3:0] r, input logic rd);
    bit acc;
    bit found;
    int cand;
    acc = m_valid && rd;
    if (acc) begin
      m_pend[m_out] = 1'b0;
      m_last        = m_out;
    end
    if (e) for (int i = 0; i < 4; i++) if (r[i]) m_pend[i] = 1'b1;
    if (!m_valid || acc) begin
      found = 1'b0;
      for (int k = 0; k < 4; k++) begin
`ifdef REQ_ENCODER_ROUND_ROBIN_EN
        cand = (m_last + 1 + k) % 4;
`else
        cand = k;
`endif
        if (!found && m_pend[cand]) begin
          found = 1'b1;
          m_out = cand;
        end
      end
      m_valid = found;
    end
  endtask

  // Called at a negedge: apply inputs, take one rising edge, compare at the
  // following negedge.
  task automatic cycle(input logic e, input logic [3:0] r, input logic rd);
    ena       = e;
    req       = r;
    out_ready = rd;
    @(posedge clk);
    model_step(e, r, rd);
    @(negedge clk);
    check_eq("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
    check_eq("out", {30'd0, out}, m_out);
    check_eq("pending", {28'd0, pending}, {28'd0, model_pend_vec()});
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n     = 1'b0;
    ena       = 1'b0;
    req       = '0;
    out_ready = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n     = 1'b0;
    ena       = 1'b0;
    req       = '0;
    out_ready = 1'b0;
    model_reset();
    #12;
    check_eq("reset_valid", {31'd0, out_valid}, 32'd0);
    check_eq("reset_out", {30'd0, out}, 32'd0);
    check_eq("reset_pending", {28'd0, pending}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single request
    do_reset();
    cycle(1'b1, 4'b0100, 1'b1);
    check_eq("single_valid", {31'd0, out_valid}, 32'd1);
    check_eq("single_out", {30'd0, out}, 32'd2);
    cycle(1'b1, 4'b0000, 1'b1);
    check_eq("single_idle", {31'd0, out_valid}, 32'd0);
    check_eq("single_pending", {28'd0, pending}, 32'd0);

    // Two requests in one cycle, granted one per cycle
    do_reset();
    cycle(1'b1, 4'b1010, 1'b1);
    check_eq("multi_first", {30'd0, out}, 32'd1);
    cycle(1'b1, 4'b0000, 1'b1);
    check_eq("multi_second", {30'd0, out}, 32'd3);
    check_eq("multi_second_valid", {31'd0, out_valid}, 32'd1);
    cycle(1'b1, 4'b0000, 1'b1);
    check_eq("multi_idle", {31'd0, out_valid}, 32'd0);

    // Backpressure: presented index held, no re-arbitration
    do_reset();
    cycle(1'b1, 4'b0001, 1'b0);
    cycle(1'b1, 4'b0000, 1'b0);
    cycle(1'b1, 4'b1000, 1'b0);
    cycle(1'b1, 4'b0000, 1'b0);
    cycle(1'b1, 4'b0000, 1'b0);
    check_eq("bp_hold_out", {30'd0, out}, 32'd0);
    check_eq("bp_hold_valid", {31'd0, out_valid}, 32'd1);
    check_eq("bp_pending", {28'd0, pending}, 32'h9);
    cycle(1'b1, 4'b0000, 1'b1);
    check_eq("bp_next", {30'd0, out}, 32'd3);
    cycle(1'b1, 4'b0000, 1'b1);
    check_eq("bp_idle", {31'd0, out_valid}, 32'd0);

    // Same bit re-requested while being accepted
    do_reset();
    cycle(1'b1, 4'b0001, 1'b1);
    cycle(1'b1, 4'b0001, 1'b1);
    check_eq("clash_valid", {31'd0, out_valid}, 32'd1);
    check_eq("clash_out", {30'd0, out}, 32'd0);
    cycle(1'b1, 4'b0000, 1'b1);
    check_eq("clash_idle", {31'd0, out_valid}, 32'd0);

    // Capture disabled
    do_reset();
    cycle(1'b0, 4'b1111, 1'b1);
    cycle(1'b0, 4'b1111, 1'b1);
    check_eq("ena_off_valid", {31'd0, out_valid}, 32'd0);
    check_eq("ena_off_pending", {28'd0, pending}, 32'd0);

    // All lines held: fixed priority keeps granting 0, rotation walks 0..3,0
    do_reset();
    for (int k = 0; k < 5; k++) begin
      cycle(1'b1, 4'b1111, 1'b1);
`ifdef REQ_ENCODER_ROUND_ROBIN_EN
      check_eq("rr_seq", {30'd0, out}, k % 4);
`else
      check_eq("fixed_seq", {30'd0, out}, 32'd0);
`endif
    end

    // Asynchronous reset in the middle of a grant
    cycle(1'b1, 4'b0110, 1'b0);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_eq("async_rst_valid", {31'd0, out_valid}, 32'd0);
    check_eq("async_rst_out", {30'd0, out}, 32'd0);
    check_eq("async_rst_pending", {28'd0, pending}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      cycle(($urandom_range(0, 3) != 0),
            4'($urandom_range(0, 15) & $urandom_range(0, 15)),
            ($urandom_range(0, 2) != 0));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_req_encoder
